// File: rtl/negate_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : negate_seq_ctrl_if
// Description : Handshake bundle for the wide negate / absolute-value
//               sequencer. The upstream side offers operands and collects
//               results (master). The sequencer owns the ready, result and
//               status signals (slave).
//   in_valid  : operand offered               (master -> slave)
//   in_ready  : sequencer can accept          (slave  -> master)
//   in_data   : operand, two's complement     (master -> slave)
//   in_abs    : 0 = negate, 1 = abs value     (master -> slave)
//   out_valid : result available              (slave  -> master)
//   out_ready : downstream accepts result     (master -> slave)
//   out_data  : result                        (slave  -> master)
//   out_ovf   : most-negative operand negated (slave  -> master)
//   busy      : operation in flight           (slave  -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface negate_seq_ctrl_if #(
  parameter int NBYTES = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [8*NBYTES-1:0]   in_data;
  logic                  in_abs;
  logic                  out_valid;
  logic                  out_ready;
  logic [8*NBYTES-1:0]   out_data;
  logic                  out_ovf;
  logic                  busy;

  modport master (
    output in_valid, in_data, in_abs, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, busy
  );

  modport slave (
    input  in_valid, in_data, in_abs, out_ready,
    output in_ready, out_valid, out_data, out_ovf, busy
  );
endinterface
`default_nettype wire

// File: rtl/negate_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : negate_seq_ctrl
// Description : Applies two's-complement negation (or absolute value) to an
//               NBYTES-wide operand using one 8-bit negate slice, one byte per
//               cycle, LSB byte first, with the +1 carried between bytes.
//   clk   : clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : negate_seq_ctrl_if.slave (operand in, result out, busy)
// Revision    : 1.0 - initial release
// ============================================================================
module negate_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  negate_seq_ctrl_if.slave   bus
);
  localparam int            DW       = 8 * NBYTES;
  localparam int            IW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
  localparam logic [DW-1:0] MIN_VAL  = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [DW-1:0]   r_op;
  logic [IW-1:0]   r_idx;
  logic            r_carry;
  logic            r_neg;
  logic            r_ovf_pend;
  logic [DW-1:0]   r_out_data;
  logic            r_out_ovf;

  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_busy;
  logic            w_accept;
  logic            w_last;
  logic            w_neg_in;
  logic [7:0]      w_b;
  logic [7:0]      w_byte_res;
  logic [DW-1:0]   w_result;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Handshake outputs are gated by rst_n so they read inactive for the
  // whole reset cycle, not only after the reset edge.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = rst_n;
        if (bus.in_valid) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_busy = rst_n;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_busy      = rst_n;
        w_out_valid = rst_n;
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ----------------------------------------------------------- datapath
  assign w_accept   = w_in_ready & bus.in_valid;
  assign w_last     = (r_idx == LAST_IDX);
  // A non-negative operand passes through unchanged in abs mode.
  assign w_neg_in   = ~bus.in_abs | bus.in_data[DW-1];
  // The operand register shifts right each RUN cycle, so the current byte
  // is always in the low lane.
  assign w_b        = r_op[7:0];
  assign w_byte_res = r_neg ? (~w_b + {7'd0, r_carry}) : w_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op       <= '0;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_neg      <= 1'b0;
      r_ovf_pend <= 1'b0;
      r_out_data <= '0;
      r_out_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_op       <= bus.in_data;
      r_idx      <= '0;
      r_carry    <= 1'b1;
      r_neg      <= w_neg_in;
      r_ovf_pend <= w_neg_in && (bus.in_data == MIN_VAL);
    end else if (r_state == S_RUN) begin
      r_op  <= r_op >> 8;
      r_idx <= r_idx + 1'b1;
      if (r_neg) begin
        r_carry <= r_carry & (w_b == 8'h00);
      end
      // The result register only changes on completion, so it keeps the
      // previous result visible throughout RUN.
      if (w_last) begin
        r_out_data <= w_result;
        r_out_ovf  <= r_ovf_pend;
      end
    end
  end

  // Partial result: finished bytes enter at the top and shift down, so
  // after the last byte the assembled word is {current byte, partial}.
  generate
    if (NBYTES > 1) begin : g_wide
      logic [DW-9:0] r_part;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_part <= '0;
        end else if (r_state == S_RUN) begin
          r_part <= w_result[DW-1:8];
        end
      end

      assign w_result = {w_byte_res, r_part};
    end else begin : g_narrow
      assign w_result = w_byte_res;
    end
  endgenerate

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.out_data  = r_out_data;
  assign bus.out_ovf   = r_out_ovf;

endmodule
`default_nettype wire
